// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_t   : controller states (IDLE, MD_BUSY, HALT)
//   MULT_LAT       : multiply occupancy in cycles
//   DIV_LAT        : divide occupancy in cycles
//   md_init_count  : busy-counter preload for a newly accepted mult/div
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_BUSY = 2'd1,
        HALT    = 2'd2
    } ctrl_state_t;

    localparam int unsigned MULT_LAT = 4;
    localparam int unsigned DIV_LAT  = 32;
    localparam int unsigned CNT_W    = 5;

    // The counter is preloaded with latency-1 so that it reaches zero on
    // the last busy cycle.
    function automatic logic [CNT_W-1:0] md_init_count(input logic is_mult);
        return is_mult ? CNT_W'(MULT_LAT - 1) : CNT_W'(DIV_LAT - 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master : pipeline side, drives ID/EX/MEM/WB status, receives controls
//   slave  : hazard controller side
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_md_start;
    logic       id_md_is_mult;
    logic       id_lhr_ren;
    logic       ex_dm_ren;
    logic       ex_rf_wen;
    logic [4:0] ex_rf_waddr;
    logic       mem_branch_taken;
    logic       wb_syscall;
    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_clr;
    logic       id_ex_clr;
    logic       ex_mem_clr;
    logic       md_busy;
    logic       halt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_start, id_md_is_mult,
               id_lhr_ren, ex_dm_ren, ex_rf_wen, ex_rf_waddr, mem_branch_taken,
               wb_syscall,
        input  pc_stall, if_id_stall, if_id_clr, id_ex_clr, ex_mem_clr,
               md_busy, halt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_start, id_md_is_mult,
               id_lhr_ren, ex_dm_ren, ex_rf_wen, ex_rf_waddr, mem_branch_taken,
               wb_syscall,
        output pc_stall, if_id_stall, if_id_clr, id_ex_clr, ex_mem_clr,
               md_busy, halt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// Multiply/divide occupancy counter.
//   clk, rst  : clock, asynchronous active-high reset (clears count)
//   load      : preload with load_val
//   load_val  : preload value
//   dec       : decrement (saturates at zero)
//   cnt       : current count
//   zero      : count is zero
module md_busy_counter
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div interlocks, branch
// flush and syscall halt.
//   clk, rst : clock, asynchronous active-high reset
//   ctrl     : pipe_hazard_ctrl_if.slave bundle (ID/EX/MEM/WB status in,
//              stall/clear controls, md_busy and halt out)
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  ctrl
);

    ctrl_state_t      state;
    logic             halt_q;
    logic             md_busy_q;
    logic             load_use;
    logic             md_hazard;
    logic             stall;
    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        load_use = ctrl.ex_dm_ren && ctrl.ex_rf_wen && (ctrl.ex_rf_waddr != '0) &&
                   ((ctrl.id_uses_rs && (ctrl.id_rs == ctrl.ex_rf_waddr)) ||
                    (ctrl.id_uses_rt && (ctrl.id_rt == ctrl.ex_rf_waddr)));
        md_hazard = (state == MD_BUSY) && (ctrl.id_lhr_ren || ctrl.id_md_start);
        stall     = load_use || md_hazard;
        accept    = (state == IDLE) && ctrl.id_md_start && !stall &&
                    !ctrl.mem_branch_taken;
        // A syscall reaching WB freezes the counter for the halted state.
        cnt_load  = accept && !ctrl.wb_syscall;
        cnt_dec   = (state == MD_BUSY) && !ctrl.wb_syscall;
    end

    // Priority: halt, then branch flush, then stall.
    always_comb begin
        ctrl.pc_stall    = 1'b0;
        ctrl.if_id_stall = 1'b0;
        ctrl.if_id_clr   = 1'b0;
        ctrl.id_ex_clr   = 1'b0;
        ctrl.ex_mem_clr  = 1'b0;
        if (state == HALT) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_clr   = 1'b1;
        end else if (ctrl.mem_branch_taken) begin
            ctrl.if_id_clr  = 1'b1;
            ctrl.id_ex_clr  = 1'b1;
            ctrl.ex_mem_clr = 1'b1;
        end else if (stall) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            halt_q    <= 1'b0;
            md_busy_q <= 1'b0;
        end else if (ctrl.wb_syscall || (state == HALT)) begin
            state     <= HALT;
            halt_q    <= 1'b1;
            md_busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= MD_BUSY;
                        md_busy_q <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt_zero) begin
                        state     <= IDLE;
                        md_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    md_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl.md_busy = md_busy_q;
    assign ctrl.halt    = halt_q;

    md_busy_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (md_init_count(ctrl.id_md_is_mult)),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs            = 5'd0;
        bus.id_rt            = 5'd0;
        bus.id_uses_rs       = 1'b0;
        bus.id_uses_rt       = 1'b0;
        bus.id_md_start      = 1'b0;
        bus.id_md_is_mult    = 1'b0;
        bus.id_lhr_ren       = 1'b0;
        bus.ex_dm_ren        = 1'b0;
        bus.ex_rf_wen        = 1'b0;
        bus.ex_rf_waddr      = 5'd0;
        bus.mem_branch_taken = 1'b0;
        bus.wb_syscall       = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        got = {bus.pc_stall, bus.if_id_stall, bus.if_id_clr, bus.id_ex_clr,
               bus.ex_mem_clr, bus.md_busy, bus.halt};
        total++;
        if (got !== 7'b0000000) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected 0000000", got);
        end
        // Stall logic stays live from inputs while reset is held.
        bus.ex_dm_ren = 1'b1; bus.ex_rf_wen = 1'b1; bus.ex_rf_waddr = 5'd8;
        bus.id_uses_rs = 1'b1; bus.id_rs = 5'd8;
        #1;
        got = {bus.pc_stall, bus.if_id_stall, bus.if_id_clr, bus.id_ex_clr,
               bus.ex_mem_clr, bus.md_busy, bus.halt};
        total++;
        if (got !== 7'b1101000) begin
            bad++;
            $display("FAIL reset_load_use: got %b expected 1101000", got);
        end
        clear_inputs();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        logic [4:0] got;
        // load $t0 in EX, ID reads rs=$t0
        bus.ex_dm_ren = 1'b1; bus.ex_rf_wen = 1'b1; bus.ex_rf_waddr = 5'd8;
        bus.id_uses_rs = 1'b1; bus.id_rs = 5'd8;
        #1;
        got = {bus.pc_stall, bus.if_id_stall, bus.if_id_clr, bus.id_ex_clr, bus.ex_mem_clr};
        total++;
        if (got !== 5'b11010) begin
            bad++;
            $display("FAIL load_use_rs: got %b expected 11010", got);
        end
        step();
        clear_inputs();
        #1;
        total++;
        if (bus.pc_stall !== 1'b0) begin
            bad++;
            $display("FAIL load_use_one_cycle: got %b expected 0", bus.pc_stall);
        end
        // rt match
        bus.ex_dm_ren = 1'b1; bus.ex_rf_wen = 1'b1; bus.ex_rf_waddr = 5'd9;
        bus.id_uses_rt = 1'b1; bus.id_rt = 5'd9; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd3;
        #1;
        total++;
        if (bus.id_ex_clr !== 1'b1) begin
            bad++;
            $display("FAIL load_use_rt: got %b expected 1", bus.id_ex_clr);
        end
        // rt matches but ID does not read rt
        bus.id_uses_rt = 1'b0;
        #1;
        total++;
        if (bus.pc_stall !== 1'b0) begin
            bad++;
            $display("FAIL load_use_rt_unused: got %b expected 0", bus.pc_stall);
        end
        // $zero destination never stalls
        bus.ex_rf_waddr = 5'd0; bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1;
        #1;
        total++;
        if (bus.pc_stall !== 1'b0) begin
            bad++;
            $display("FAIL load_use_zero_reg: got %b expected 0", bus.pc_stall);
        end
        // not a load (ALU result is forwarded)
        bus.ex_rf_waddr = 5'd12; bus.id_rs = 5'd12; bus.ex_dm_ren = 1'b0;
        #1;
        total++;
        if (bus.pc_stall !== 1'b0) begin
            bad++;
            $display("FAIL load_use_not_load: got %b expected 0", bus.pc_stall);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_md(input logic is_mult, input int unsigned lat);
        int unsigned busy_bad;
        busy_bad = 0;
        bus.id_md_start = 1'b1; bus.id_md_is_mult = is_mult;
        #1;
        total++;
        if (bus.pc_stall !== 1'b0 || bus.md_busy !== 1'b0) begin
            bad++;
            $display("FAIL md_accept_no_stall: got %b%b expected 00", bus.pc_stall, bus.md_busy);
        end
        step();
        bus.id_md_start = 1'b0; bus.id_md_is_mult = 1'b0;
        bus.id_lhr_ren = 1'b1;  // mfhi waiting in ID
        for (int unsigned i = 0; i < lat; i++) begin
            #1;
            if (bus.md_busy !== 1'b1 || bus.pc_stall !== 1'b1 || bus.if_id_stall !== 1'b1 ||
                bus.id_ex_clr !== 1'b1) begin
                busy_bad++;
                $display("FAIL md_busy_cycle%0d: got busy=%b stall=%b expected 1 1",
                         i, bus.md_busy, bus.pc_stall);
            end
            step();
        end
        total++;
        if (busy_bad != 0) begin
            bad++;
            $display("FAIL md_busy_window: got %0d bad cycles expected 0", busy_bad);
        end
        #1;
        total++;
        if (bus.md_busy !== 1'b0 || bus.pc_stall !== 1'b0) begin
            bad++;
            $display("FAIL md_done: got busy=%b stall=%b expected 0 0", bus.md_busy, bus.pc_stall);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_flush();
        logic [4:0] got;
        int unsigned n;
        bus.ex_dm_ren = 1'b1; bus.ex_rf_wen = 1'b1; bus.ex_rf_waddr = 5'd8;
        bus.id_uses_rs = 1'b1; bus.id_rs = 5'd8;
        bus.mem_branch_taken = 1'b1;
        bus.id_md_start = 1'b1; bus.id_md_is_mult = 1'b1;
        #1;
        got = {bus.pc_stall, bus.if_id_stall, bus.if_id_clr, bus.id_ex_clr, bus.ex_mem_clr};
        total++;
        if (got !== 5'b00111) begin
            bad++;
            $display("FAIL flush_over_stall: got %b expected 00111", got);
        end
        // branch alone still flushes and blocks MD acceptance
        bus.ex_dm_ren = 1'b0;
        step();
        clear_inputs();
        #1;
        total++;
        if (bus.md_busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_md_not_accepted: got %b expected 0", bus.md_busy);
        end
        // branch flush during MD_BUSY does not abort the mult
        bus.id_md_start = 1'b1; bus.id_md_is_mult = 1'b1;
        step();
        clear_inputs();
        bus.mem_branch_taken = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.md_busy === 1'b1) n++;
            step();
            bus.mem_branch_taken = 1'b0;
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL flush_keeps_md: got %0d busy cycles expected 4", n);
        end
    endtask

    task automatic test_halt();
        logic [6:0] got;
        int unsigned halt_bad;
        halt_bad = 0;
        bus.id_md_start = 1'b1; bus.id_md_is_mult = 1'b0;
        step();
        clear_inputs();
        step(); step();
        bus.wb_syscall = 1'b1;
        #1;
        total++;
        if (bus.md_busy !== 1'b1 || bus.halt !== 1'b0) begin
            bad++;
            $display("FAIL halt_not_yet: got busy=%b halt=%b expected 1 0", bus.md_busy, bus.halt);
        end
        step();
        clear_inputs();
        bus.mem_branch_taken = 1'b1;  // must not flush while halted
        #1;
        got = {bus.pc_stall, bus.if_id_stall, bus.if_id_clr, bus.id_ex_clr,
               bus.ex_mem_clr, bus.md_busy, bus.halt};
        total++;
        if (got !== 7'b1101001) begin
            bad++;
            $display("FAIL halt_outputs: got %b expected 1101001", got);
        end
        bus.mem_branch_taken = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.halt !== 1'b1 || bus.md_busy !== 1'b0) halt_bad++;
        end
        total++;
        if (halt_bad != 0) begin
            bad++;
            $display("FAIL halt_hold: got %0d bad cycles expected 0", halt_bad);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.halt !== 1'b0 || bus.pc_stall !== 1'b0) begin
            bad++;
            $display("FAIL halt_reset: got halt=%b stall=%b expected 0 0", bus.halt, bus.pc_stall);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_syscall_with_branch();
        bus.wb_syscall = 1'b1; bus.mem_branch_taken = 1'b1;
        #1;
        total++;
        if (bus.if_id_clr !== 1'b1 || bus.ex_mem_clr !== 1'b1 || bus.pc_stall !== 1'b0 ||
            bus.halt !== 1'b0) begin
            bad++;
            $display("FAIL sys_branch_flush: got clr=%b%b stall=%b halt=%b expected 11 0 0",
                     bus.if_id_clr, bus.ex_mem_clr, bus.pc_stall, bus.halt);
        end
        step();
        clear_inputs();
        #1;
        total++;
        if (bus.halt !== 1'b1 || bus.if_id_clr !== 1'b0) begin
            bad++;
            $display("FAIL sys_branch_halt: got halt=%b clr=%b expected 1 0", bus.halt, bus.if_id_clr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_div();
        int unsigned n;
        bus.id_md_start = 1'b1; bus.id_md_is_mult = 1'b0;
        step();  // counter = 31
        clear_inputs();
        repeat (14) step();  // counter = 17
        total++;
        if (bus.md_busy !== 1'b1) begin
            bad++;
            $display("FAIL div_busy_before_rst: got %b expected 1", bus.md_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.md_busy !== 1'b0) begin
            bad++;
            $display("FAIL div_async_rst: got %b expected 0", bus.md_busy);
        end
        step();
        rst = 1'b0;
        step();
        total++;
        if (bus.md_busy !== 1'b0) begin
            bad++;
            $display("FAIL div_discarded: got %b expected 0", bus.md_busy);
        end
        bus.id_md_start = 1'b1; bus.id_md_is_mult = 1'b1;
        step();
        clear_inputs();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.md_busy === 1'b1) n++;
            step();
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL mult_after_rst: got %0d busy cycles expected 4", n);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();
        #2;
        test_reset();
        test_load_use();
        test_md(1'b1, 4);
        test_md(1'b0, 32);
        test_flush();
        test_halt();
        test_syscall_with_branch();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
